// File: rtl/eth_pkg.sv
// Shared definitions for the GMII receive rate adapter.
//   - speed encodings (SPD_10 / SPD_100 / SPD_1000; 2'b11 also means 1000)
//   - receive FSM state enum
//   - bit positions of the fields in an RGMII in-band status word
package eth_pkg;

  localparam logic [1:0] SPD_10   = 2'b00;
  localparam logic [1:0] SPD_100  = 2'b01;
  localparam logic [1:0] SPD_1000 = 2'b10;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FRAME = 1'b1
  } rx_state_e;

  // In-band status word fields (low nibble; high nibble must repeat it).
  localparam int ST_LINK_UP_BIT = 0;
  localparam int ST_SPEED_LSB   = 1;
  localparam int ST_SPEED_MSB   = 2;
  localparam int ST_FDX_BIT     = 3;

  // 2'b10 and 2'b11 both select gigabit operation.
  function automatic logic is_gige(input logic [1:0] spd);
    return spd[1];
  endfunction

endpackage

// File: rtl/gmii_rx_rate_adapter_if.sv
// Bundle of the GMII receive bus and the byte-stream output of the adapter.
//   gmii_rx_dv / gmii_rx_er / gmii_rxd : PHY-side receive bus
//   out_valid / out_data / out_sof / out_eof / out_err : byte stream
// Handshake: there is no ready. out_valid is a single-cycle strobe and the
// consumer must take out_data (and sof/eof/err) in every cycle it is high;
// out_sof/out_eof are only meaningful with out_valid, out_err only with out_eof.
// Modports: master = PHY/bridge side (drives GMII, observes the stream),
//           slave  = the adapter (consumes GMII, drives the stream).
interface gmii_rx_rate_adapter_if ();
  logic       gmii_rx_dv;
  logic       gmii_rx_er;
  logic [7:0] gmii_rxd;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_sof;
  logic       out_eof;
  logic       out_err;

  modport master (
    output gmii_rx_dv, gmii_rx_er, gmii_rxd,
    input  out_valid, out_data, out_sof, out_eof, out_err
  );

  modport slave (
    input  gmii_rx_dv, gmii_rx_er, gmii_rxd,
    output out_valid, out_data, out_sof, out_eof, out_err
  );
endinterface

// File: rtl/rgmii_inband_status.sv
// RGMII in-band status decoder.
// While dv=0 and er=0 the bus carries a status word whose two nibbles repeat;
// a consistent word updates link_up / link_speed / link_fdx one cycle later.
// Inconsistent words and any cycle with dv or er high are ignored.
// Ports: clk, rst_n (sync, active-low), dv, er, rxd in;
//        link_up, link_speed, link_fdx out.
module rgmii_inband_status
  import eth_pkg::*;
#(
  parameter int STATUS_EN = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       dv,
  input  logic       er,
  input  logic [7:0] rxd,
  output logic       link_up,
  output logic [1:0] link_speed,
  output logic       link_fdx
);

  logic sample_ok;
  assign sample_ok = (STATUS_EN != 0) && !dv && !er && (rxd[3:0] == rxd[7:4]);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      link_up    <= 1'b0;
      link_speed <= SPD_1000;
      link_fdx   <= 1'b1;
    end else if (sample_ok) begin
      link_up    <= rxd[ST_LINK_UP_BIT];
      link_speed <= rxd[ST_SPEED_MSB:ST_SPEED_LSB];
      link_fdx   <= rxd[ST_FDX_BIT];
    end
  end

endmodule

// File: rtl/gmii_rx_rate_adapter.sv
// Receive-side rate adapter: GMII (1000) or nibble GMII (10/100) to a byte
// stream with frame delimiters, plus in-band status decode and frame/error
// counters.
// Ports:
//   gmii_rx_clk, rst_n (sync, active-low)
//   speed_cfg   : speed used when SPEED_AUTO=0
//   bus         : GMII in / byte stream out (slave modport)
//   link_up, link_speed, link_fdx : decoded in-band status
//   frame_cnt, err_cnt : saturating good/bad frame counters
//   state_dbg   : current receive FSM state
module gmii_rx_rate_adapter
  import eth_pkg::*;
#(
  parameter int SPEED_AUTO = 1,
  parameter int STATUS_EN  = 1,
  parameter int CNT_W      = 16
) (
  input  logic                  gmii_rx_clk,
  input  logic                  rst_n,
  input  logic [1:0]            speed_cfg,
  gmii_rx_rate_adapter_if.slave bus,
  output logic                  link_up,
  output logic [1:0]            link_speed,
  output logic                  link_fdx,
  output logic [CNT_W-1:0]      frame_cnt,
  output logic [CNT_W-1:0]      err_cnt,
  output rx_state_e             state_dbg
);

  logic       dv, er;
  logic [7:0] rxd;
  assign dv  = bus.gmii_rx_dv;
  assign er  = bus.gmii_rx_er;
  assign rxd = bus.gmii_rxd;

  rgmii_inband_status #(.STATUS_EN(STATUS_EN)) u_status (
    .clk        (gmii_rx_clk),
    .rst_n      (rst_n),
    .dv         (dv),
    .er         (er),
    .rxd        (rxd),
    .link_up    (link_up),
    .link_speed (link_speed),
    .link_fdx   (link_fdx)
  );

  logic [1:0] eff_speed;
  assign eff_speed = (SPEED_AUTO != 0) ? link_speed : speed_cfg;

  rx_state_e  state;
  logic       dv_q;        // dv last cycle; resets to 1 so a dv already high
                           // at reset release is not seen as a rise
  logic       gige_q;      // speed frozen for the current frame
  logic       nib_odd;     // low nibble captured, waiting for the high one
  logic [3:0] nib_lo;
  logic [7:0] hold_data;
  logic       hold_valid;
  logic       first_q;     // next emission is the first of the frame
  logic       bad_q;       // sticky frame error
  logic       good_p, bad_p;

  logic       out_valid_q, out_sof_q, out_eof_q, out_err_q;
  logic [7:0] out_data_q;
  logic [CNT_W-1:0] frame_cnt_q, err_cnt_q;

  // A byte completes this cycle: every dv cycle in 1000 mode, every second
  // nibble in 10/100 mode (the first nibble of a frame is always a low one).
  logic       byte_done;
  logic [7:0] byte_val;
  always_comb begin
    byte_done = 1'b0;
    byte_val  = rxd;
    if (state == ST_IDLE) begin
      byte_done = dv && !dv_q && is_gige(eff_speed);
    end else if (dv) begin
      if (gige_q) begin
        byte_done = 1'b1;
      end else if (nib_odd) begin
        byte_done = 1'b1;
        byte_val  = {rxd[3:0], nib_lo};
      end
    end
  end

  always_ff @(posedge gmii_rx_clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      dv_q        <= 1'b1;
      gige_q      <= 1'b1;
      nib_odd     <= 1'b0;
      nib_lo      <= 4'h0;
      hold_data   <= 8'h00;
      hold_valid  <= 1'b0;
      first_q     <= 1'b0;
      bad_q       <= 1'b0;
      good_p      <= 1'b0;
      bad_p       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'h00;
      out_sof_q   <= 1'b0;
      out_eof_q   <= 1'b0;
      out_err_q   <= 1'b0;
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      dv_q        <= dv;
      out_valid_q <= 1'b0;
      out_sof_q   <= 1'b0;
      out_eof_q   <= 1'b0;
      out_err_q   <= 1'b0;
      good_p      <= 1'b0;
      bad_p       <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (dv && !dv_q) begin
            state      <= ST_FRAME;
            gige_q     <= is_gige(eff_speed);
            bad_q      <= er;
            first_q    <= 1'b1;
            nib_lo     <= rxd[3:0];
            nib_odd    <= !is_gige(eff_speed);
            hold_valid <= byte_done;
            hold_data  <= byte_val;
          end
        end
        ST_FRAME: begin
          if (!dv) begin
            // End of frame: flush the held byte as eof. A pending low nibble
            // (dribble) is dropped and marks the frame bad. In 10/100 this
            // eof strobe may directly follow the previous byte's strobe.
            state      <= ST_IDLE;
            hold_valid <= 1'b0;
            nib_odd    <= 1'b0;
            if (hold_valid) begin
              out_valid_q <= 1'b1;
              out_data_q  <= hold_data;
              out_sof_q   <= first_q;
              out_eof_q   <= 1'b1;
              out_err_q   <= bad_q || nib_odd;
            end
            // A frame that never completed a byte is counted as bad.
            good_p <= hold_valid && !(bad_q || nib_odd);
            bad_p  <= !(hold_valid && !(bad_q || nib_odd));
          end else begin
            if (er) begin
              bad_q <= 1'b1;
            end
            if (!gige_q) begin
              nib_odd <= !nib_odd;
              if (!nib_odd) begin
                nib_lo <= rxd[3:0];
              end
            end
            if (byte_done) begin
              hold_data  <= byte_val;
              hold_valid <= 1'b1;
              if (hold_valid) begin
                out_valid_q <= 1'b1;
                out_data_q  <= hold_data;
                out_sof_q   <= first_q;
                first_q     <= 1'b0;
              end
            end
          end
        end
        default: state <= ST_IDLE;
      endcase

      if (good_p && (frame_cnt_q != {CNT_W{1'b1}})) begin
        frame_cnt_q <= frame_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (bad_p && (err_cnt_q != {CNT_W{1'b1}})) begin
        err_cnt_q <= err_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sof   = out_sof_q;
  assign bus.out_eof   = out_eof_q;
  assign bus.out_err   = out_err_q;
  assign frame_cnt     = frame_cnt_q;
  assign err_cnt       = err_cnt_q;
  assign state_dbg     = state;

endmodule

// File: tb/tb_gmii_rx_rate_adapter.sv
// Bench for gmii_rx_rate_adapter: directed frames from the test plan followed
// by randomized frames at random speeds, checked against a reference model.
module tb_gmii_rx_rate_adapter;
  import eth_pkg::*;

  localparam int CNT_W = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam int EXP_W = 43;  // {edge[31:0], sof, eof, err, data[7:0]}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] speed_cfg = 2'b00;
  logic link_up, link_fdx;
  logic [1:0] link_speed;
  logic [CNT_W-1:0] frame_cnt, err_cnt;
  rx_state_e state_dbg;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  gmii_rx_rate_adapter_if bus ();

  gmii_rx_rate_adapter #(.SPEED_AUTO(1), .STATUS_EN(1), .CNT_W(CNT_W)) dut (
    .gmii_rx_clk (clk),
    .rst_n       (rst_n),
    .speed_cfg   (speed_cfg),
    .bus         (bus.slave),
    .link_up     (link_up),
    .link_speed  (link_speed),
    .link_fdx    (link_fdx),
    .frame_cnt   (frame_cnt),
    .err_cnt     (err_cnt),
    .state_dbg   (state_dbg)
  );

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  logic [EXP_W-1:0] exp_q[$];
  logic [7:0] units_q[$];   // bytes (1000) or nibbles in [3:0] (10/100)
  logic [7:0] idle_word = 8'hDD;
  logic       m_up = 1'b0;
  logic [1:0] m_speed = SPD_1000;
  logic       m_fdx = 1'b1;
  int         m_good = 0;
  int         m_bad = 0;

  function automatic void sample_status(input logic [7:0] w);
    if (w[3:0] == w[7:4]) begin
      m_up    = w[0];
      m_speed = w[2:1];
      m_fdx   = w[3];
    end
  endfunction

  function automatic int sat_inc(input int v);
    return (v >= CNT_MAX) ? CNT_MAX : v + 1;
  endfunction

  // ---------------- scoreboard monitor ----------------
  logic [EXP_W-1:0] mon_e;
  always @(negedge clk) begin
    if (bus.out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("spurious_strobe", 64'(exp_q.size()), 64'd1);
      end else begin
        mon_e = exp_q.pop_front();
        check("strobe_edge", 64'(cyc), 64'(mon_e[42:11]));
        check("strobe_word", {53'd0, bus.out_sof, bus.out_eof, bus.out_err, bus.out_data},
              {53'd0, mon_e[10:0]});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n, input logic [7:0] w);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.gmii_rx_dv = 1'b0;
      bus.gmii_rx_er = 1'b0;
      bus.gmii_rxd   = w;
      sample_status(w);
    end
  endtask

  task automatic carrier(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.gmii_rx_dv = 1'b0;
      bus.gmii_rx_er = 1'b1;
      bus.gmii_rxd   = 8'($urandom_range(0, 255));
    end
  endtask

  task automatic check_reset_values();
    check("rst_valid", 64'(bus.out_valid), 64'd0);
    check("rst_data", {53'd0, bus.out_sof, bus.out_eof, bus.out_err, bus.out_data}, 64'd0);
    check("rst_link", {60'd0, link_up, link_speed, link_fdx}, {60'd0, 1'b0, SPD_1000, 1'b1});
    check("rst_frame_cnt", 64'(frame_cnt), 64'd0);
    check("rst_err_cnt", 64'(err_cnt), 64'd0);
    check("rst_state", 64'(state_dbg), 64'(ST_IDLE));
  endtask

  task automatic post_checks();
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    check("frame_cnt", 64'(frame_cnt), 64'(m_good));
    check("err_cnt", 64'(err_cnt), 64'(m_bad));
    check("link_status", {60'd0, link_up, link_speed, link_fdx}, {60'd0, m_up, m_speed, m_fdx});
    check("state_idle", 64'(state_dbg), 64'(ST_IDLE));
  endtask

  // Drives units_q as one frame; er_at / rst_at are unit indices (-1 = none).
  task automatic send_frame(input int er_at, input int rst_at);
    int n_units, n_bytes, start, fall, rst_edge, edge_k;
    logic gige, bad;
    logic [7:0] b;
    n_units = units_q.size();
    gige    = m_speed[1];
    n_bytes = gige ? n_units : n_units / 2;
    bad     = (er_at >= 0) || (!gige && (n_units % 2 == 1));
    @(negedge clk);
    start    = cyc + 1;
    fall     = start + n_units;
    rst_edge = (rst_at >= 0) ? start + rst_at : fall + 1000;
    // Byte k is shown when byte k+1 completes, the last one at the fall edge.
    for (int k = 0; k < n_bytes; k++) begin
      b = gige ? units_q[k] : {units_q[2*k+1][3:0], units_q[2*k][3:0]};
      if (k == n_bytes - 1) edge_k = fall;
      else edge_k = gige ? start + k + 1 : start + 2 * (k + 1) + 1;
      if (edge_k < rst_edge)
        exp_q.push_back({edge_k[31:0], (k == 0), (k == n_bytes - 1),
                         ((k == n_bytes - 1) && bad), b});
    end
    if (rst_at >= 0) begin
      m_good = 0; m_bad = 0; m_up = 1'b0; m_speed = SPD_1000; m_fdx = 1'b1;
    end else if (n_bytes > 0 && !bad) begin
      m_good = sat_inc(m_good);
    end else begin
      m_bad = sat_inc(m_bad);
    end
    for (int i = 0; i < n_units; i++) begin
      if (i > 0) @(negedge clk);
      if (i == 1 && (rst_at < 0 || rst_at > 1)) check("state_in_frame", 64'(state_dbg), 64'(ST_FRAME));
      if (rst_at >= 0 && i == rst_at + 1) check_reset_values();
      bus.gmii_rx_dv = 1'b1;
      bus.gmii_rx_er = (i == er_at);
      bus.gmii_rxd   = gige ? units_q[i] : {4'($urandom_range(0, 15)), units_q[i][3:0]};
      rst_n          = (i != rst_at);
    end
    @(negedge clk);
    bus.gmii_rx_dv = 1'b0;
    bus.gmii_rx_er = 1'b0;
    bus.gmii_rxd   = idle_word;
    rst_n          = 1'b1;
    sample_status(idle_word);
  endtask

  task automatic push_preamble(input logic gige);
    units_q.delete();
    if (gige) begin
      for (int i = 0; i < 7; i++) units_q.push_back(8'h55);
      units_q.push_back(8'hD5);
    end else begin
      for (int i = 0; i < 15; i++) units_q.push_back(8'h05);
      units_q.push_back(8'h0D);
    end
  endtask

  task automatic set_mode(input logic [7:0] w);
    idle_word = w;
    idle(4, w);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    int len, er_at;
    logic [7:0] words[4];
    bus.gmii_rx_dv = 1'b0;
    bus.gmii_rx_er = 1'b0;
    bus.gmii_rxd   = 8'hDD;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values();
    rst_n = 1'b1;

    // In-band status: consistent word, then mismatched and carrier words.
    set_mode(8'hDD);
    post_checks();
    idle(1, 8'h0B);
    carrier(2);
    idle(1, 8'hDD);
    post_checks();

    // 1000 mode, 64-byte frame.
    push_preamble(1'b1);
    for (int i = 0; i < 56; i++) units_q.push_back(8'($urandom_range(0, 255)));
    send_frame(-1, -1);
    idle(6, idle_word);
    post_checks();

    // 1000 mode, er for one cycle mid-frame.
    push_preamble(1'b1);
    for (int i = 0; i < 12; i++) units_q.push_back(8'($urandom_range(0, 255)));
    send_frame(10, -1);
    idle(6, idle_word);
    post_checks();

    // 100 mode: preamble/SFD nibbles, payload 0x12 0x34.
    set_mode(8'hBB);
    push_preamble(1'b0);
    units_q.push_back(8'h02); units_q.push_back(8'h01);
    units_q.push_back(8'h04); units_q.push_back(8'h03);
    send_frame(-1, -1);
    idle(6, idle_word);
    post_checks();

    // 100 mode, 9 nibbles (dribble).
    units_q.delete();
    for (int i = 0; i < 9; i++) units_q.push_back(8'($urandom_range(0, 15)));
    send_frame(-1, -1);
    idle(6, idle_word);
    post_checks();

    // 100 mode, zero-byte frame.
    units_q.delete();
    units_q.push_back(8'h05);
    send_frame(-1, -1);
    idle(6, idle_word);
    post_checks();

    // 10 mode random frame.
    set_mode(8'h99);
    units_q.delete();
    for (int i = 0; i < 30; i++) units_q.push_back(8'($urandom_range(0, 15)));
    send_frame(-1, -1);
    idle(6, idle_word);
    post_checks();

    // Reset mid-frame in 1000 mode, dv held high past reset, then a clean frame.
    set_mode(8'hDD);
    push_preamble(1'b1);
    for (int i = 0; i < 22; i++) units_q.push_back(8'($urandom_range(0, 255)));
    send_frame(-1, 12);
    idle(6, idle_word);
    post_checks();
    push_preamble(1'b1);
    for (int i = 0; i < 8; i++) units_q.push_back(8'($urandom_range(0, 255)));
    send_frame(-1, -1);
    idle(6, idle_word);
    post_checks();

    // Randomized frames at random speeds (also drives counters into saturation).
    words[0] = 8'hDD; words[1] = 8'hBB; words[2] = 8'h99; words[3] = 8'h55;
    for (int f = 0; f < 26; f++) begin
      set_mode(words[$urandom_range(0, 3)]);
      units_q.delete();
      len = m_speed[1] ? $urandom_range(1, 40) : $urandom_range(1, 60);
      for (int i = 0; i < len; i++)
        units_q.push_back(m_speed[1] ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 15)));
      er_at = (len > 2 && $urandom_range(0, 3) == 0) ? $urandom_range(1, len - 1) : -1;
      send_frame(er_at, -1);
      idle($urandom_range(6, 10), idle_word);
      post_checks();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
